// File: rtl/pwm_decoder.sv
// PWM line decoder: measures high time and period per rising-edge frame and flags a stuck line.
// Optional duty4 divider is built when the macro PWM_DEC_DUTY4_EN is defined.
module pwm_decoder #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pwm_in,
    output logic          meas_valid,
    output logic [CW-1:0] meas_high,
    output logic [CW-1:0] meas_period,
    output logic          stuck,
    output logic          stuck_level,
    output logic [3:0]    duty4,
    output logic          duty_valid
);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_LIMIT = {CW{1'b1}} - CNT_ONE;

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    state_t        state;
    logic          sync1;
    logic          s;
    logic          p;
    logic          rise;
    logic [CW-1:0] period_cnt;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] idle_cnt;
    logic          idle_done;

    assign rise = s & ~p;

    // Two-flop synchronizer plus previous-level register for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            p     <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            s     <= sync1;
            p     <= s;
        end
    end

    // Frame measurement and stuck-line detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            period_cnt  <= '0;
            high_cnt    <= '0;
            idle_cnt    <= '0;
            idle_done   <= 1'b0;
            meas_valid  <= 1'b0;
            meas_high   <= '0;
            meas_period <= '0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state      <= MEAS;
                        period_cnt <= CNT_ONE;
                        high_cnt   <= CNT_ONE;
                        stuck      <= 1'b0;
                    end else if (!idle_done) begin
                        // Fires once per IDLE entry, after 2^CW-1 edgeless cycles
                        idle_cnt <= idle_cnt + CNT_ONE;
                        if (idle_cnt == CNT_LIMIT) begin
                            stuck       <= 1'b1;
                            stuck_level <= s;
                            idle_done   <= 1'b1;
                        end
                    end
                end
                MEAS: begin
                    if (rise) begin
                        meas_valid  <= 1'b1;
                        meas_period <= period_cnt;
                        meas_high   <= high_cnt;
                        period_cnt  <= CNT_ONE;
                        high_cnt    <= CNT_ONE;
                    end else if (period_cnt == CNT_LIMIT) begin
                        stuck       <= 1'b1;
                        stuck_level <= s;
                        state       <= IDLE;
                        period_cnt  <= '0;
                        high_cnt    <= '0;
                        idle_cnt    <= '0;
                        idle_done   <= 1'b0;
                    end else begin
                        period_cnt <= period_cnt + CNT_ONE;
                        high_cnt   <= high_cnt + {{(CW-1){1'b0}}, s};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PWM_DEC_DUTY4_EN
    logic [CW:0]   div_rem;
    logic [3:0]    div_q;
    logic [2:0]    div_steps;
    logic [CW:0]   div_shift;
    logic          div_ge;

    assign div_shift = {div_rem[CW-1:0], 1'b0};
    assign div_ge    = (div_shift >= {1'b0, meas_period});

    // Restoring divider, one quotient bit per cycle; a new frame restarts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_rem    <= '0;
            div_q      <= '0;
            div_steps  <= '0;
            duty4      <= '0;
            duty_valid <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (meas_valid) begin
                div_rem   <= {1'b0, meas_high};
                div_q     <= '0;
                div_steps <= 3'd4;
            end else if (div_steps != 3'd0) begin
                div_rem   <= div_ge ? (div_shift - {1'b0, meas_period}) : div_shift;
                div_q     <= {div_q[2:0], div_ge};
                div_steps <= div_steps - 3'd1;
                if (div_steps == 3'd1) begin
                    duty4      <= {div_q[2:0], div_ge};
                    duty_valid <= 1'b1;
                end
            end
        end
    end
`else
    assign duty4      = 4'd0;
    assign duty_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: timestamp-based reference model checked every cycle,
// directed frame scenarios plus randomized frames, holds and a mid-run reset.
module tb_pwm_decoder;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pwm_in = 1'b0;
    logic          meas_valid;
    logic [CW-1:0] meas_high;
    logic [CW-1:0] meas_period;
    logic          stuck;
    logic          stuck_level;
    logic [3:0]    duty4;
    logic          duty_valid;

    pwm_decoder #(.CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .meas_valid (meas_valid),
        .meas_high  (meas_high),
        .meas_period(meas_period),
        .stuck      (stuck),
        .stuck_level(stuck_level),
        .duty4      (duty4),
        .duty_valid (duty_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mv_count = 0;
    int dv_count = 0;

    // Reference model state: edge timestamps since reset release
    int  e;
    int  hist[$];
    bit  armed;
    int  last_rise;
    int  high_sum;
    int  idle_start;
    bit  idle_fired;
    bit  exp_mv, exp_stuck, exp_level, exp_dv;
    int  exp_mh, exp_mp, exp_duty;
    bit  div_pending;
    int  div_due, div_val;
    bit  ms, mr;

    // Line level seen by the core at edge j is the input sampled two edges earlier
    function automatic bit s_at(int j);
        if (j < 3) return 1'b0;
        return hist[j-3][0];
    endfunction

    task automatic check_output(string name, int actual, int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            e = 0; hist.delete(); armed = 0; last_rise = 0; high_sum = 0;
            idle_start = 0; idle_fired = 0; exp_mv = 0; exp_stuck = 0; exp_level = 0;
            exp_dv = 0; exp_mh = 0; exp_mp = 0; exp_duty = 0; div_pending = 0;
            div_due = 0; div_val = 0;
        end else begin
            e++;
            hist.push_back(int'(pwm_in));
            ms = s_at(e);
            mr = ms && !s_at(e - 1);
            exp_mv = 0;
            exp_dv = 0;
`ifdef PWM_DEC_DUTY4_EN
            if (div_pending && div_due == e) begin
                exp_dv = 1; exp_duty = div_val; div_pending = 0;
            end
`endif
            if (mr) begin
                if (armed) begin
                    exp_mv = 1; exp_mp = e - last_rise; exp_mh = high_sum;
                end
                armed = 1; last_rise = e; high_sum = 1; exp_stuck = 0;
            end else if (armed) begin
                high_sum += int'(ms);
                if (e - last_rise == 254) begin
                    exp_stuck = 1; exp_level = ms; armed = 0;
                    idle_start = e; idle_fired = 0;
                end
            end else if (!idle_fired && e - idle_start == 255) begin
                exp_stuck = 1; exp_level = ms; idle_fired = 1;
            end
`ifdef PWM_DEC_DUTY4_EN
            if (exp_mv) begin
                div_pending = 1; div_due = e + 5; div_val = (16 * exp_mh) / exp_mp;
            end
`endif
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            check_output("meas_valid", meas_valid, exp_mv);
            check_output("meas_high", meas_high, exp_mh);
            check_output("meas_period", meas_period, exp_mp);
            check_output("stuck", stuck, exp_stuck);
            check_output("stuck_level", stuck_level, exp_level);
            check_output("duty4", duty4, exp_duty);
            check_output("duty_valid", duty_valid, exp_dv);
            if (meas_valid) mv_count++;
            if (duty_valid) dv_count++;
        end
    end

    task automatic apply_stimulus(int high, int period, int frames);
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < period; i++) begin
                @(negedge clk);
                pwm_in = (i < high);
            end
        end
    endtask

    task automatic hold_line(bit level, int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            pwm_in = level;
        end
    endtask

    initial begin
        int p, w;
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 16-cycle frames with 5 high cycles
        mv_count = 0;
        apply_stimulus(5, 16, 6);
        hold_line(1'b0, 8);
        check_output("t1_pulses", mv_count, 5);
        check_output("t1_period", meas_period, 16);
        check_output("t1_high", meas_high, 5);
`ifdef PWM_DEC_DUTY4_EN
        check_output("t1_duty4", duty4, 5);
`endif

        // Duty sweep
        for (int sw = 1; sw <= 15; sw++) begin
            apply_stimulus(sw, 16, 3);
            check_output("t2_high", meas_high, sw);
            check_output("t2_period", meas_period, 16);
`ifdef PWM_DEC_DUTY4_EN
            check_output("t2_duty4", duty4, sw);
`endif
        end

        // Line held low, then recovery
        hold_line(1'b0, 300);
        check_output("t3_stuck", stuck, 1);
        check_output("t3_level", stuck_level, 0);
        mv_count = 0;
        apply_stimulus(3, 16, 2);
        hold_line(1'b0, 4);
        check_output("t3_stuck_clear", stuck, 0);
        check_output("t3_pulses", mv_count, 1);
        check_output("t3_high", meas_high, 3);

        // Line held high after frames
        apply_stimulus(7, 16, 3);
        hold_line(1'b1, 300);
        check_output("t4_stuck", stuck, 1);
        check_output("t4_level", stuck_level, 1);
        check_output("t4_period", meas_period, 16);
        check_output("t4_high", meas_high, 7);

        // Reset 8 cycles into a frame, line high at release
        apply_stimulus(10, 16, 3);
        hold_line(1'b1, 8);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_output("t5_rst_valid", meas_valid, 0);
        check_output("t5_rst_period", meas_period, 0);
        check_output("t5_rst_stuck", stuck, 0);
        reset = 1'b0;
        hold_line(1'b1, 1);
        hold_line(1'b0, 6);
        apply_stimulus(10, 16, 3);
        hold_line(1'b0, 4);
        check_output("t5_high", meas_high, 10);
        check_output("t5_period", meas_period, 16);

        // Period-3 frames keep restarting the divider
        dv_count = 0;
        mv_count = 0;
        apply_stimulus(1, 3, 20);
        check_output("t6_duty_pulses", dv_count, 0);
        check_output("t6_period", meas_period, 3);
        check_output("t6_high", meas_high, 1);

        // Randomized frames, long frames around the timeout boundary, holds
        for (int it = 0; it < 48; it++) begin
            if (it % 8 == 7) begin
                p = $urandom_range(250, 258);
                w = $urandom_range(1, p - 1);
                apply_stimulus(w, p, $urandom_range(1, 2));
            end else if (it % 12 == 5) begin
                hold_line(1'($urandom_range(0, 1)), $urandom_range(240, 520));
            end else if (it == 30) begin
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                p = $urandom_range(2, 40);
                w = $urandom_range(1, p - 1);
                apply_stimulus(w, p, $urandom_range(1, 4));
            end
        end
        hold_line(1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
